// File: rtl/memory_load_unit.sv
// Tile fetcher: streams loadSize*loadSize words from the data RAM into a flat
// buffer that the convolution layer copies in a single cycle after loadDone.
module memory_load_unit #(
  parameter int unsigned DATA_SZ   = 16,
  parameter int unsigned ADDR_SZ   = 16,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      loadEnable,
  input  logic [ADDR_SZ-1:0]        loadAddr,
  input  logic [DATA_SZ-1:0]        loadSize,
  output logic signed [DATA_SZ-1:0] loadOut [0:MAX_WORDS-1],
  output logic                      loadDone,
  output logic                      loadTruncated,
  output logic                      busy,
  output logic                      memRead,
  output logic [ADDR_SZ-1:0]        memAddr,
  input  logic signed [DATA_SZ-1:0] memData
);

  localparam int unsigned IDX_W  = $clog2(MAX_WORDS);
  localparam int unsigned CNT_W  = $clog2(MAX_WORDS + 1);
  localparam int unsigned PROD_W = 2 * DATA_SZ;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t             state, state_d;
  logic [ADDR_SZ-1:0] base, base_d;
  logic [CNT_W-1:0]   n_words, n_d;
  logic               trunc, trunc_d;
  logic [IDX_W-1:0]   issue_idx, idx_d;
  logic               cap_valid, cap_v_d;
  logic [IDX_W-1:0]   cap_idx, cap_i_d;
  logic               rd_d, done_d, clear_buf;
  logic [ADDR_SZ-1:0] addr_d;
  logic [PROD_W-1:0]  n_full;
  logic               n_over;
  logic [CNT_W-1:0]   n_clamp;

  // Word count at double width so a 33x33 or larger request is detected, then clamped.
  assign n_full  = PROD_W'(loadSize) * PROD_W'(loadSize);
  assign n_over  = n_full > PROD_W'(MAX_WORDS);
  assign n_clamp = n_over ? CNT_W'(MAX_WORDS) : CNT_W'(n_full);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      base          <= '0;
      n_words       <= '0;
      trunc         <= 1'b0;
      issue_idx     <= '0;
      cap_valid     <= 1'b0;
      cap_idx       <= '0;
      memRead       <= 1'b0;
      memAddr       <= '0;
      loadDone      <= 1'b0;
      loadTruncated <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_d;
      base          <= base_d;
      n_words       <= n_d;
      trunc         <= trunc_d;
      issue_idx     <= idx_d;
      cap_valid     <= cap_v_d;
      cap_idx       <= cap_i_d;
      memRead       <= rd_d;
      memAddr       <= addr_d;
      loadDone      <= done_d;
      loadTruncated <= done_d & trunc;
      busy          <= (state_d != IDLE);
    end
  end

  // Next-state, request latch, issue sequencing and next registered outputs.
  always_comb begin
    state_d   = state;
    base_d    = base;
    n_d       = n_words;
    trunc_d   = trunc;
    idx_d     = issue_idx;
    cap_v_d   = 1'b0;
    cap_i_d   = cap_idx;
    rd_d      = 1'b0;
    addr_d    = memAddr;
    done_d    = 1'b0;
    clear_buf = 1'b0;
    case (state)
      IDLE: begin
        if (loadEnable) begin
          base_d    = loadAddr;
          n_d       = n_clamp;
          trunc_d   = n_over;
          idx_d     = '0;
          clear_buf = 1'b1;
          if (n_clamp == '0) begin
            state_d = DRAIN;
          end else begin
            state_d = READ;
            rd_d    = 1'b1;
            addr_d  = loadAddr;
          end
        end
      end
      READ: begin
        cap_v_d = 1'b1;
        cap_i_d = issue_idx;
        if (CNT_W'(issue_idx) == n_words - CNT_W'(1)) begin
          state_d = DRAIN;
        end else begin
          idx_d  = issue_idx + IDX_W'(1);
          rd_d   = 1'b1;
          addr_d = base + ADDR_SZ'(issue_idx) + ADDR_SZ'(1);
        end
      end
      DRAIN: begin
        state_d = DONE;
        done_d  = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Tile buffer: wiped on accept, written one cycle after each issue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned k = 0; k < MAX_WORDS; k++) loadOut[k] <= '0;
    end else if (clear_buf) begin
      for (int unsigned k = 0; k < MAX_WORDS; k++) loadOut[k] <= '0;
    end else if (cap_valid) begin
      loadOut[cap_idx] <= memData;
    end
  end

endmodule
